// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-to-memory arbiter: state encoding and
// block geometry.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        D_WRITE = 2'b01,
        D_FILL  = 2'b10,
        I_FILL  = 2'b11
    } arb_state_e;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;

endpackage

// File: rtl/block_fill_seq.sv
// Block fill sequencer shared by both fill states: latches the block base,
// issues one read per cycle and counts returning words.
module block_fill_seq #(
    parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
    parameter int WORD_IDX_W      = 3,
    parameter int ADDR_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  active,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  mem_valid,
    output logic                  issue,
    output logic [ADDR_W-1:0]     issue_addr,
    output logic [WORD_IDX_W-1:0] word,
    output logic                  fill_done
);

    localparam int CNT_W = WORD_IDX_W + 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK =
        ~ADDR_W'((1 << mem_arb_pkg::BLOCK_OFFSET_W) - 1);

    logic [ADDR_W-1:0]     base;
    logic [CNT_W-1:0]      issue_cnt;
    logic [WORD_IDX_W-1:0] recv_cnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (start) begin
            base      <= addr & BLOCK_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (active) begin
            if (issue)
                issue_cnt <= issue_cnt + CNT_W'(1);
            if (mem_valid)
                recv_cnt <= recv_cnt + WORD_IDX_W'(1);
        end
    end

    // Issue counter carries one extra bit so it parks at WORDS_PER_BLOCK.
    assign issue      = active && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign issue_addr = base + ADDR_W'({issue_cnt[WORD_IDX_W-1:0], 1'b0});
    assign word       = recv_cnt;
    assign fill_done  = active && mem_valid &&
                        (recv_cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores
// onto a single pipelined memory port and steers fill data back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
    parameter int WORD_IDX_W      = 3,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_miss,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_stall,
    output logic                  i_filling,
    output logic                  i_valid,
    output logic [WORD_IDX_W-1:0] i_word,
    output logic [DATA_W-1:0]     i_data,
    output logic                  i_done,
    input  logic                  d_miss,
    input  logic                  d_wr,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_stall,
    output logic                  d_filling,
    output logic                  d_valid,
    output logic [WORD_IDX_W-1:0] d_word,
    output logic [DATA_W-1:0]     d_data,
    output logic                  d_done,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid
);

    arb_state_e            state, next_state;
    logic                  start, fill_active, issue, fill_done;
    logic [ADDR_W-1:0]     fill_addr, issue_addr;
    logic [WORD_IDX_W-1:0] word;

    assign fill_active = (state == D_FILL) || (state == I_FILL);

    block_fill_seq #(
        .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
        .WORD_IDX_W     (WORD_IDX_W),
        .ADDR_W         (ADDR_W)
    ) u_fill_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .active    (fill_active),
        .addr      (fill_addr),
        .mem_valid (mem_valid),
        .issue     (issue),
        .issue_addr(issue_addr),
        .word      (word),
        .fill_done (fill_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        fill_addr  = i_addr;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_filling  = 1'b0;
        i_valid    = 1'b0;
        i_word     = '0;
        i_data     = '0;
        i_done     = 1'b0;
        d_filling  = 1'b0;
        d_valid    = 1'b0;
        d_word     = '0;
        d_data     = '0;
        d_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_wr) begin
                    next_state = D_WRITE;
                end else if (d_miss) begin
                    next_state = D_FILL;
                    start      = 1'b1;
                    fill_addr  = d_addr;
                end else if (i_miss) begin
                    next_state = I_FILL;
                    start      = 1'b1;
                end
            end
            D_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                d_done     = 1'b1;
                next_state = IDLE;
            end
            D_FILL: begin
                mem_enable = issue;
                mem_addr   = issue ? issue_addr : '0;
                d_filling  = 1'b1;
                d_valid    = mem_valid;
                d_word     = mem_valid ? word : '0;
                d_data     = mem_valid ? mem_rdata : '0;
                d_done     = fill_done;
                if (fill_done)
                    next_state = IDLE;
            end
            I_FILL: begin
                mem_enable = issue;
                mem_addr   = issue ? issue_addr : '0;
                i_filling  = 1'b1;
                i_valid    = mem_valid;
                i_word     = mem_valid ? word : '0;
                i_data     = mem_valid ? mem_rdata : '0;
                i_done     = fill_done;
                if (fill_done)
                    next_state = IDLE;
            end
        endcase
    end

    // Stalls are qualified by rst_n so every output reads 0 while in reset.
    assign i_stall = rst_n & i_miss & ~i_done;
    assign d_stall = rst_n & (d_miss | d_wr) & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency (4-cycle) memory model
// returning addr ^ 16'h5A5A for each read.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_stall, i_filling, i_valid, i_done;
    logic [2:0]  i_word;
    logic [15:0] i_data;
    logic        d_stall, d_filling, d_valid, d_done;
    logic [2:0]  d_word;
    logic [15:0] d_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_valid;
    logic        mdl_valid  = 1'b0;
    logic        spur_valid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic        e_en, e_wr;
    logic [15:0] e_addr, e_wdata;
    logic        e_i_stall, e_i_filling, e_i_valid, e_i_done;
    logic [2:0]  e_i_word;
    logic [15:0] e_i_data;
    logic        e_d_stall, e_d_filling, e_d_valid, e_d_done;
    logic [2:0]  e_d_word;
    logic [15:0] e_d_data;

    always #5 clk = ~clk;

    assign mem_valid = mdl_valid | spur_valid;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_miss    (i_miss),
        .i_addr    (i_addr),
        .i_stall   (i_stall),
        .i_filling (i_filling),
        .i_valid   (i_valid),
        .i_word    (i_word),
        .i_data    (i_data),
        .i_done    (i_done),
        .d_miss    (d_miss),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_stall   (d_stall),
        .d_filling (d_filling),
        .d_valid   (d_valid),
        .d_word    (d_word),
        .d_data    (d_data),
        .d_done    (d_done),
        .mem_enable(mem_enable),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    // Memory model: reads seen in cycle c come back during cycle c+LAT.
    logic        slot_v [16] = '{default: 1'b0};
    logic [15:0] slot_d [16] = '{default: 16'h0};
    int unsigned gcyc = 0;

    always begin
        logic [3:0] idx;
        @(negedge clk);
        if (rst_n === 1'b1 && mem_enable === 1'b1 && mem_wr === 1'b0) begin
            idx = 4'(gcyc + LAT);
            slot_v[idx] = 1'b1;
            slot_d[idx] = mem_addr ^ 16'h5A5A;
        end
        @(posedge clk);
        #1;
        gcyc++;
        idx = 4'(gcyc);
        mdl_valid = slot_v[idx];
        mem_rdata = slot_v[idx] ? slot_d[idx] : 16'h0;
        slot_v[idx] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        e_en = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
        e_i_stall = 1'b0; e_i_filling = 1'b0; e_i_valid = 1'b0; e_i_done = 1'b0;
        e_i_word = 3'd0; e_i_data = 16'h0;
        e_d_stall = 1'b0; e_d_filling = 1'b0; e_d_valid = 1'b0; e_d_done = 1'b0;
        e_d_word = 3'd0; e_d_data = 16'h0;
    endtask

    // Expected fill timeline: first read in cycle s, reads s..s+7,
    // words s+4..s+11, done with the last word.
    task automatic set_fill(input int c, input int s, input logic [15:0] b, input bit is_d);
        logic        f, v, dn;
        logic [2:0]  w;
        logic [15:0] dat;
        f   = (c >= s) && (c <= s + 11);
        v   = (c >= s + 4) && (c <= s + 11);
        dn  = (c == s + 11);
        w   = v ? 3'(c - s - 4) : 3'd0;
        dat = v ? ((b + 16'(2 * (c - s - 4))) ^ 16'h5A5A) : 16'h0;
        if (c >= s && c <= s + 7) begin
            e_en   = 1'b1;
            e_addr = b + 16'(2 * (c - s));
        end
        if (is_d) begin
            e_d_filling = f; e_d_valid = v; e_d_done = dn; e_d_word = w; e_d_data = dat;
        end else begin
            e_i_filling = f; e_i_valid = v; e_i_done = dn; e_i_word = w; e_i_data = dat;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " mem_enable"}, 32'(mem_enable), 32'(e_en));
        check({tag, " mem_wr"},     32'(mem_wr),     32'(e_wr));
        check({tag, " mem_addr"},   32'(mem_addr),   32'(e_addr));
        check({tag, " mem_wdata"},  32'(mem_wdata),  32'(e_wdata));
        check({tag, " i_stall"},    32'(i_stall),    32'(e_i_stall));
        check({tag, " i_filling"},  32'(i_filling),  32'(e_i_filling));
        check({tag, " i_valid"},    32'(i_valid),    32'(e_i_valid));
        check({tag, " i_word"},     32'(i_word),     32'(e_i_word));
        check({tag, " i_data"},     32'(i_data),     32'(e_i_data));
        check({tag, " i_done"},     32'(i_done),     32'(e_i_done));
        check({tag, " d_stall"},    32'(d_stall),    32'(e_d_stall));
        check({tag, " d_filling"},  32'(d_filling),  32'(e_d_filling));
        check({tag, " d_valid"},    32'(d_valid),    32'(e_d_valid));
        check({tag, " d_word"},     32'(d_word),     32'(e_d_word));
        check({tag, " d_data"},     32'(d_data),     32'(e_d_data));
        check({tag, " d_done"},     32'(d_done),     32'(e_d_done));
    endtask

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;

        // Reset state, with requests present to show stalls are held low.
        cyc_step();
        i_miss = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'h5555;
        @(negedge clk);
        clear_exp();
        check_all("reset");
        cyc_step();
        i_miss = 1'b0; d_wr = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        clear_exp();
        check_all("post_reset");
        cyc_step();

        // Spurious mem_valid while idle.
        for (int c = 0; c < 3; c++) begin
            spur_valid = (c == 1);
            @(negedge clk);
            clear_exp();
            check_all($sformatf("spur c%0d", c));
            cyc_step();
        end
        spur_valid = 1'b0;

        // Lone I fill at 0x1236.
        i_miss = 1'b1; i_addr = 16'h1236;
        for (int c = 0; c < 14; c++) begin
            if (c == 13) i_miss = 1'b0;
            @(negedge clk);
            clear_exp();
            set_fill(c, 1, 16'h1230, 1'b0);
            e_i_stall = (c <= 11);
            check_all($sformatf("lone_i c%0d", c));
            cyc_step();
        end

        // Simultaneous D and I misses: D first, then one idle cycle, then I.
        d_miss = 1'b1; d_addr = 16'h4000; i_miss = 1'b1; i_addr = 16'h0010;
        for (int c = 0; c < 27; c++) begin
            if (c == 13) d_miss = 1'b0;
            if (c == 26) i_miss = 1'b0;
            @(negedge clk);
            clear_exp();
            set_fill(c, 1, 16'h4000, 1'b1);
            set_fill(c, 14, 16'h0010, 1'b0);
            e_d_stall = (c <= 11);
            e_i_stall = (c <= 24);
            check_all($sformatf("both c%0d", c));
            cyc_step();
        end

        // Store arriving during an I fill waits for the fill and one idle cycle.
        i_miss = 1'b1; i_addr = 16'h0100;
        for (int c = 0; c < 16; c++) begin
            if (c == 3) begin d_wr = 1'b1; d_addr = 16'h2002; d_wdata = 16'hBEEF; end
            if (c == 13) i_miss = 1'b0;
            if (c == 15) d_wr = 1'b0;
            @(negedge clk);
            clear_exp();
            set_fill(c, 1, 16'h0100, 1'b0);
            e_i_stall = (c <= 11);
            e_d_stall = (c >= 3) && (c <= 13);
            if (c == 14) begin
                e_en = 1'b1; e_wr = 1'b1; e_addr = 16'h2002; e_wdata = 16'hBEEF;
                e_d_done = 1'b1;
            end
            check_all($sformatf("wr_wait c%0d", c));
            cyc_step();
        end

        // I miss withdrawn at word 2: fill completes; pending D miss waits.
        i_miss = 1'b1; i_addr = 16'hFFF8;
        for (int c = 0; c < 27; c++) begin
            if (c == 7) begin i_miss = 1'b0; d_miss = 1'b1; d_addr = 16'h0306; end
            if (c == 26) d_miss = 1'b0;
            @(negedge clk);
            clear_exp();
            set_fill(c, 1, 16'hFFF0, 1'b0);
            set_fill(c, 14, 16'h0300, 1'b1);
            e_i_stall = (c < 7);
            e_d_stall = (c >= 7) && (c <= 24);
            check_all($sformatf("flush c%0d", c));
            cyc_step();
        end

        // Reset at issue k=3 of an I fill; in-flight words arrive after release.
        i_miss = 1'b1; i_addr = 16'h0500;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                rst_n = 1'b0; i_miss = 1'b0;
                #1;
                check("rst_async mem_enable", 32'(mem_enable), 32'(1'b0));
                check("rst_async i_filling",  32'(i_filling),  32'(1'b0));
            end
            if (c == 5) rst_n = 1'b1;
            @(negedge clk);
            clear_exp();
            if (c <= 3) begin
                set_fill(c, 1, 16'h0500, 1'b0);
                e_i_stall = 1'b1;
            end
            check_all($sformatf("rst_mid c%0d", c));
            cyc_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
